// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity bit, stop period.
// Bit timing comes from a shared 16x-baud s_tick enable; tx is always driven from a flop.
module uart_tx #(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_tick,
   input  logic       tx_start,
   input  logic [7:0] din,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done_tick,
   output logic [2:0] dbg_state_o
);

   localparam int             SCW       = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam logic [SCW-1:0] BIT_LAST  = SCW'(15);
   localparam logic [SCW-1:0] STOP_LAST = SCW'(SB_TICK - 1);
   localparam logic [2:0]     N_LAST    = 3'(DBIT - 1);
   localparam logic           PAR_SEED  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t          state_q;
   logic [SCW-1:0]  s_cnt_q;
   logic [2:0]      n_cnt_q;
   logic [DBIT-1:0] b_reg_q;
   logic            parity_q;
   logic            tx_q;
   logic            done_q;

   // tx_q is loaded with the level of the state being entered, so the line
   // changes on the same edge as the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         s_cnt_q  <= '0;
         n_cnt_q  <= '0;
         b_reg_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (tx_start) begin
                  state_q  <= START;
                  b_reg_q  <= din[DBIT-1:0];
                  s_cnt_q  <= '0;
                  parity_q <= PAR_SEED;
                  tx_q     <= 1'b0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_cnt_q == BIT_LAST) begin
                     state_q <= DATA;
                     s_cnt_q <= '0;
                     n_cnt_q <= '0;
                     tx_q    <= b_reg_q[0];
                  end else begin
                     s_cnt_q <= s_cnt_q + 1'b1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_cnt_q == BIT_LAST) begin
                     s_cnt_q  <= '0;
                     b_reg_q  <= b_reg_q >> 1;
                     parity_q <= parity_q ^ b_reg_q[0];
                     if (n_cnt_q == N_LAST) begin
                        if (PARITY_EN != 0) begin
                           state_q <= PARITY;
                           tx_q    <= parity_q ^ b_reg_q[0];
                        end else begin
                           state_q <= STOP;
                           tx_q    <= 1'b1;
                        end
                     end else begin
                        n_cnt_q <= n_cnt_q + 1'b1;
                        tx_q    <= b_reg_q[1];
                     end
                  end else begin
                     s_cnt_q <= s_cnt_q + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (s_tick) begin
                  if (s_cnt_q == BIT_LAST) begin
                     state_q <= STOP;
                     s_cnt_q <= '0;
                     tx_q    <= 1'b1;
                  end else begin
                     s_cnt_q <= s_cnt_q + 1'b1;
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (s_cnt_q == STOP_LAST) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                     tx_q    <= 1'b1;
                  end else begin
                     s_cnt_q <= s_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign tx           = tx_q;
   assign tx_busy      = (state_q != IDLE);
   assign tx_done_tick = done_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default framing, even/odd parity, ignored restarts,
// back-to-back frames, slow s_tick and mid-frame reset.
module tb_uart_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, s_tick, tx_start;
   logic [7:0] din;

   logic       tx_d, busy_d, done_d;
   logic [2:0] st_d;
   logic       tx_pe, busy_pe, done_pe;
   logic [2:0] st_pe;
   logic       tx_po, busy_po, done_po;
   logic [2:0] st_po;

   int checks = 0;
   int errors = 0;

   uart_tx u_def (
      .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
      .tx(tx_d), .tx_busy(busy_d), .tx_done_tick(done_d), .dbg_state_o(st_d)
   );

   uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_pe (
      .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
      .tx(tx_pe), .tx_busy(busy_pe), .tx_done_tick(done_pe), .dbg_state_o(st_pe)
   );

   uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_po (
      .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
      .tx(tx_po), .tx_busy(busy_po), .tx_done_tick(done_po), .dbg_state_o(st_po)
   );

   task automatic clk_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      tx_start = 1'b0;
      s_tick   = 1'b0;
      din      = 8'h00;
      clk_edge();
      rst = 1'b0;
   endtask

   // Expected line level c cycles after the accepting edge; one bit = 16*div clocks.
   function automatic logic exp_tx(input logic [7:0] d, input int c, input int div,
                                   input int pen, input logic pbit);
      int slot;
      if (c < 1) return 1'b1;
      slot = (c - 1) / (16 * div);
      if (slot == 0) return 1'b0;
      if (slot <= 8) return d[slot-1];
      if (pen != 0 && slot == 9) return pbit;
      return 1'b1;
   endfunction

   task automatic test_reset();
      rst = 1'b1; tx_start = 1'b1; s_tick = 1'b1; din = 8'hFF;
      clk_edge();
      clk_edge();
      checks++; if (tx_d !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx_d); end
      checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_d); end
      checks++; if (done_d !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_d); end
      checks++; if (st_d !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", st_d); end
      checks++; if (tx_pe !== 1'b1 || busy_pe !== 1'b0 || done_pe !== 1'b0) begin
         errors++; $display("FAIL reset_pe got=%b%b%b exp=100", tx_pe, busy_pe, done_pe); end
      checks++; if (tx_po !== 1'b1 || busy_po !== 1'b0 || st_po !== 3'd0) begin
         errors++; $display("FAIL reset_po got=%b%b%0d exp=100", tx_po, busy_po, st_po); end
      rst = 1'b0; tx_start = 1'b0;
      clk_edge();
      checks++; if (tx_d !== 1'b1 || busy_d !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset got=%b%b exp=10", tx_d, busy_d); end
   endtask

   task automatic test_frame_a5();
      do_reset();
      din = 8'hA5;
      for (int e = 0; e <= 170; e++) begin
         tx_start = (e == 0);
         s_tick   = 1'b1;
         clk_edge();
         checks++; if (tx_d !== exp_tx(8'hA5, e + 1, 1, 0, 1'b0)) begin
            errors++; $display("FAIL a5_tx cyc=%0d got=%b exp=%b", e + 1, tx_d, exp_tx(8'hA5, e + 1, 1, 0, 1'b0)); end
         checks++; if (busy_d !== (e + 1 <= 160)) begin
            errors++; $display("FAIL a5_busy cyc=%0d got=%b", e + 1, busy_d); end
         checks++; if (done_d !== (e + 1 == 161)) begin
            errors++; $display("FAIL a5_done cyc=%0d got=%b", e + 1, done_d); end
      end
   endtask

   task automatic test_parity();
      do_reset();
      din = 8'h07;
      for (int e = 0; e <= 185; e++) begin
         tx_start = (e == 0);
         s_tick   = 1'b1;
         clk_edge();
         checks++; if (tx_pe !== exp_tx(8'h07, e + 1, 1, 1, 1'b1)) begin
            errors++; $display("FAIL even_par_tx cyc=%0d got=%b exp=%b", e + 1, tx_pe, exp_tx(8'h07, e + 1, 1, 1, 1'b1)); end
         checks++; if (tx_po !== exp_tx(8'h07, e + 1, 1, 1, 1'b0)) begin
            errors++; $display("FAIL odd_par_tx cyc=%0d got=%b exp=%b", e + 1, tx_po, exp_tx(8'h07, e + 1, 1, 1, 1'b0)); end
         checks++; if (busy_pe !== (e + 1 <= 176)) begin
            errors++; $display("FAIL par_busy cyc=%0d got=%b", e + 1, busy_pe); end
         checks++; if (done_pe !== (e + 1 == 177) || done_po !== (e + 1 == 177)) begin
            errors++; $display("FAIL par_done cyc=%0d got=%b%b", e + 1, done_pe, done_po); end
      end
   endtask

   task automatic test_ignore_start();
      do_reset();
      for (int e = 0; e <= 200; e++) begin
         tx_start = (e == 0) || (e == 50);
         din      = (e >= 50) ? 8'hFF : 8'h3C;
         s_tick   = 1'b1;
         clk_edge();
         checks++; if (tx_d !== exp_tx(8'h3C, e + 1, 1, 0, 1'b0)) begin
            errors++; $display("FAIL ignore_tx cyc=%0d got=%b exp=%b", e + 1, tx_d, exp_tx(8'h3C, e + 1, 1, 0, 1'b0)); end
         checks++; if (busy_d !== (e + 1 <= 160)) begin
            errors++; $display("FAIL ignore_busy cyc=%0d got=%b", e + 1, busy_d); end
         checks++; if (done_d !== (e + 1 == 161)) begin
            errors++; $display("FAIL ignore_done cyc=%0d got=%b", e + 1, done_d); end
      end
   endtask

   task automatic test_back_to_back();
      int rel;
      int ndone = 0;
      do_reset();
      din      = 8'h55;
      tx_start = 1'b1;
      for (int e = 0; e <= 330; e++) begin
         s_tick = 1'b1;
         clk_edge();
         // Frames repeat every 161 clocks: 160 ticks of frame plus the done cycle.
         rel = (e % 161) + 1;
         if (done_d === 1'b1) ndone++;
         checks++; if (tx_d !== exp_tx(8'h55, rel, 1, 0, 1'b0)) begin
            errors++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", e + 1, tx_d, exp_tx(8'h55, rel, 1, 0, 1'b0)); end
         checks++; if (busy_d !== (rel <= 160)) begin
            errors++; $display("FAIL b2b_busy cyc=%0d got=%b", e + 1, busy_d); end
         checks++; if (done_d !== (rel == 161)) begin
            errors++; $display("FAIL b2b_done cyc=%0d got=%b", e + 1, done_d); end
      end
      tx_start = 1'b0;
      checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", ndone); end
   endtask

   task automatic test_slow_tick();
      logic [2:0] prev_st;
      do_reset();
      din     = 8'h96;
      prev_st = st_d;
      for (int e = 0; e <= 660; e++) begin
         tx_start = (e == 0);
         s_tick   = ((e % 4) == 0);
         clk_edge();
         checks++; if (tx_d !== exp_tx(8'h96, e + 1, 4, 0, 1'b0)) begin
            errors++; $display("FAIL slow_tx cyc=%0d got=%b exp=%b", e + 1, tx_d, exp_tx(8'h96, e + 1, 4, 0, 1'b0)); end
         checks++; if (busy_d !== (e + 1 <= 640)) begin
            errors++; $display("FAIL slow_busy cyc=%0d got=%b", e + 1, busy_d); end
         checks++; if (done_d !== (e + 1 == 641)) begin
            errors++; $display("FAIL slow_done cyc=%0d got=%b", e + 1, done_d); end
         if ((e % 4) != 0 && prev_st != 3'd0) begin
            checks++; if (st_d !== prev_st) begin
               errors++; $display("FAIL slow_freeze cyc=%0d got=%0d exp=%0d", e + 1, st_d, prev_st); end
         end
         prev_st = st_d;
      end
   endtask

   task automatic test_reset_mid();
      int c;
      logic etx, ebusy, edone;
      do_reset();
      for (int e = 0; e <= 260; e++) begin
         rst      = (e == 80);
         tx_start = (e == 0) || (e == 83);
         din      = (e >= 83) ? 8'h3C : 8'hA5;
         s_tick   = 1'b1;
         clk_edge();
         c = e + 1;
         if (c <= 80) begin
            etx = exp_tx(8'hA5, c, 1, 0, 1'b0); ebusy = 1'b1; edone = 1'b0;
         end else if (c <= 83) begin
            etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
         end else begin
            etx = exp_tx(8'h3C, c - 83, 1, 0, 1'b0); ebusy = (c - 83 <= 160); edone = (c - 83 == 161);
         end
         checks++; if (tx_d !== etx) begin
            errors++; $display("FAIL rstmid_tx cyc=%0d got=%b exp=%b", c, tx_d, etx); end
         checks++; if (busy_d !== ebusy) begin
            errors++; $display("FAIL rstmid_busy cyc=%0d got=%b exp=%b", c, busy_d, ebusy); end
         checks++; if (done_d !== edone) begin
            errors++; $display("FAIL rstmid_done cyc=%0d got=%b exp=%b", c, done_d, edone); end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; s_tick = 1'b0; tx_start = 1'b0; din = 8'h00;
      test_reset();
      test_frame_a5();
      test_parity();
      test_ignore_start();
      test_back_to_back();
      test_slow_tick();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
